regfile_write_sequencer: RTL and testbench

Synchronous write sequencer that drives the active-low write strobe, write address and write data of a 4×8 74HCT670-style register file. Requests are buffered in a 2-entry FIFO. The strobe is produced as a clock-counted pulse with programmable address setup, pulse width and hold, replacing delay-line pulse generation. It sits between the control-logic write request and the register file's write port.

---
 rtl/regfile_write_sequencer.sv | 175 +++++++++++++++++
 tb/tb_regfile_write_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_sequencer.sv
// regfile_write_sequencer
// Drives the write port (_we, wa, wd) of a 4x8 '670-style register file from
// a 2-entry request FIFO. The write strobe is built by counting clocks:
// SETUP_CYC cycles of address/data setup, PULSE_CYC cycles of _we low,
// HOLD_CYC cycles of hold, so the pulse width is PULSE_CYC x Tclk.
//
// Ports:
//   clk        system clock, rising edge
//   _reset     synchronous active-low reset
//   wr_valid   write request; accepted when wr_ready is also high
//   wr_addr    target register (2 bits)
//   wr_data    value to write (8 bits)
//   wr_ready   FIFO not full (forced low while _reset is low)
//   _we        register-file write enable, active-low, registered
//   wa, wd     register-file address / data, registered, change only on a pop
//   wr_done    high during the last HOLD cycle of each write
//   busy       sequencer not idle or FIFO non-empty
//   rd_addr, rd_data  shadow readback, present only with REGFILE_WSEQ_SHADOW_EN
//
// Optional feature macro: REGFILE_WSEQ_SHADOW_EN adds a 4x8 shadow copy of the
// register file, updated at the edge where _we rises.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | nothing in flight; pops the FIFO head if any
// SETUP | wa/wd stable, _we high, counting SETUP_CYC
// PULSE | _we low, counting PULSE_CYC
// HOLD  | _we high, wa/wd held, counting HOLD_CYC

module regfile_write_sequencer #(
   parameter int SETUP_CYC = 1,
   parameter int PULSE_CYC = 2,
   parameter int HOLD_CYC  = 1
) (
   input  logic       clk,
   input  logic       _reset,
   input  logic       wr_valid,
   input  logic [1:0] wr_addr,
   input  logic [7:0] wr_data,
   output logic       wr_ready,
   output logic       _we,
   output logic [1:0] wa,
   output logic [7:0] wd,
   output logic       wr_done,
   output logic       busy
`ifdef REGFILE_WSEQ_SHADOW_EN
   ,
   input  logic [1:0] rd_addr,
   output logic [7:0] rd_data
`endif
);

   typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

   localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
   localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
   localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;

   logic [9:0]  fifo_mem [2];
   logic        rd_ptr, wr_ptr;
   logic [1:0]  fifo_cnt;
   logic        fifo_empty, fifo_full;
   logic        push, pop;

   assign fifo_empty = (fifo_cnt == 2'd0);
   assign fifo_full  = (fifo_cnt == 2'd2);
   assign push       = wr_valid & wr_ready;

   // state register, counter, FIFO pointers and registered write-port outputs
   always_ff @(posedge clk) begin
      if (!_reset) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         rd_ptr   <= 1'b0;
         wr_ptr   <= 1'b0;
         fifo_cnt <= 2'd0;
         _we      <= 1'b1;
         wa       <= 2'd0;
         wd       <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         // _we is simply "next state is not PULSE", so it can never fall on
         // the same edge as a pop (pops only lead into SETUP)
         _we     <= (state_d != PULSE);
         if (pop) begin
            {wa, wd} <= fifo_mem[rd_ptr];
            rd_ptr   <= ~rd_ptr;
         end
         if (push)
            wr_ptr <= ~wr_ptr;
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
            2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr] <= {wr_addr, wr_data};
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               cnt_d   = SETUP_LD;
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (cnt_q == 4'd0) begin
               cnt_d   = PULSE_LD;
               state_d = PULSE;
            end
         end
         PULSE: begin
            if (cnt_q == 4'd0) begin
               cnt_d   = HOLD_LD;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (cnt_q == 4'd0) begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  cnt_d   = SETUP_LD;
                  state_d = SETUP;
               end else begin
                  cnt_d   = 4'd0;
                  state_d = IDLE;
               end
            end
         end
         default: begin
            cnt_d   = 4'd0;
            state_d = IDLE;
         end
      endcase
   end

   // outputs
   always_comb begin
      wr_ready = _reset & ~fifo_full;
      wr_done  = (state_q == HOLD) && (cnt_q == 4'd0);
      busy     = (state_q != IDLE) || !fifo_empty;
   end

`ifdef REGFILE_WSEQ_SHADOW_EN
   logic [7:0] shadow [4];

   // captured on the PULSE->HOLD edge, i.e. when the real part latches
   always_ff @(posedge clk) begin
      if (!_reset) begin
         for (int i = 0; i < 4; i++)
            shadow[i] <= 8'd0;
      end else if (state_q == PULSE && cnt_q == 4'd0) begin
         shadow[wa] <= wd;
      end
   end

   assign rd_data = shadow[rd_addr];
`endif

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Bench for regfile_write_sequencer: two instances (default timing and
// SETUP=3/PULSE=5/HOLD=2) driven with the same random request stream and
// compared each cycle against a transaction-level timeline model.

module tb_regfile_write_sequencer;

   logic       clk;
   logic       reset_b;
   logic       wr_valid;
   logic [1:0] wr_addr;
   logic [7:0] wr_data;
   logic [1:0] rd_addr;

   logic       wr_ready [2];
   logic       we_b     [2];
   logic [1:0] wa       [2];
   logic [7:0] wd       [2];
   logic       wr_done  [2];
   logic       busy     [2];
   logic [7:0] rd_data  [2];

   int errs   = 0;
   int checks = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   regfile_write_sequencer u_dut0 (
      .clk      (clk),
      ._reset   (reset_b),
      .wr_valid (wr_valid),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_ready (wr_ready[0]),
      ._we      (we_b[0]),
      .wa       (wa[0]),
      .wd       (wd[0]),
      .wr_done  (wr_done[0]),
      .busy     (busy[0])
`ifdef REGFILE_WSEQ_SHADOW_EN
      ,
      .rd_addr  (rd_addr),
      .rd_data  (rd_data[0])
`endif
   );

   regfile_write_sequencer #(.SETUP_CYC(3), .PULSE_CYC(5), .HOLD_CYC(2)) u_dut1 (
      .clk      (clk),
      ._reset   (reset_b),
      .wr_valid (wr_valid),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_ready (wr_ready[1]),
      ._we      (we_b[1]),
      .wa       (wa[1]),
      .wd       (wd[1]),
      .wr_done  (wr_done[1]),
      .busy     (busy[1])
`ifdef REGFILE_WSEQ_SHADOW_EN
      ,
      .rd_addr  (rd_addr),
      .rd_data  (rd_data[1])
`endif
   );

`ifndef REGFILE_WSEQ_SHADOW_EN
   assign rd_data[0] = 8'd0;
   assign rd_data[1] = 8'd0;
`endif

   // reference model: each write is a timeline starting at the edge that
   // dequeues it; phase p = cycles since that edge
   int         m_s   [2] = '{1, 3};
   int         m_p   [2] = '{2, 5};
   int         m_h   [2] = '{1, 2};
   logic [9:0] mq    [2][$];
   bit         act   [2];
   int         st    [2];
   logic [1:0] ewa   [2];
   logic [7:0] ewd   [2];
   logic [7:0] shd   [2][4];
   int         ecnt  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s @edge %0d: got %0h expected %0h", tag, ecnt, got, exp);
      end
   endtask

   task automatic model_edge(input int k);
      bit rdy;
      int tot;
      tot = m_s[k] + m_p[k] + m_h[k];
      if (!reset_b) begin
         mq[k].delete();
         act[k] = 0;
         ewa[k] = 2'd0;
         ewd[k] = 8'd0;
         for (int i = 0; i < 4; i++) shd[k][i] = 8'd0;
      end else begin
         rdy = (mq[k].size() < 2);
         if (act[k] && (ecnt - st[k]) == m_s[k] + m_p[k])
            shd[k][ewa[k]] = ewd[k];
         if (act[k] && (ecnt - st[k]) == tot)
            act[k] = 0;
         if (!act[k] && mq[k].size() > 0) begin
            {ewa[k], ewd[k]} = mq[k].pop_front();
            st[k]  = ecnt;
            act[k] = 1;
         end
         if (wr_valid && rdy)
            mq[k].push_back({wr_addr, wr_data});
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 2; k++) begin
         int  ph;
         bit  exp_we, exp_done;
         ph       = ecnt - st[k];
         exp_we   = !(act[k] && ph >= m_s[k] && ph < m_s[k] + m_p[k]);
         exp_done = act[k] && ph == m_s[k] + m_p[k] + m_h[k] - 1;
         chk($sformatf("we_b%0d", k),     32'(we_b[k]),     32'(exp_we));
         chk($sformatf("wa%0d", k),       32'(wa[k]),       32'(ewa[k]));
         chk($sformatf("wd%0d", k),       32'(wd[k]),       32'(ewd[k]));
         chk($sformatf("wr_done%0d", k),  32'(wr_done[k]),  32'(exp_done));
         chk($sformatf("busy%0d", k),     32'(busy[k]),     32'(act[k] || mq[k].size() > 0));
         chk($sformatf("wr_ready%0d", k), 32'(wr_ready[k]), 32'(reset_b && mq[k].size() < 2));
`ifdef REGFILE_WSEQ_SHADOW_EN
         chk($sformatf("rd_data%0d", k),  32'(rd_data[k]),  32'(shd[k][rd_addr]));
`endif
      end
   endtask

   task automatic step();
      @(posedge clk);
      ecnt++;
      model_edge(0);
      model_edge(1);
      #1;
      check_all();
      @(negedge clk);
   endtask

   initial begin
      int n;
      reset_b  = 1'b0;
      wr_valid = 1'b1;
      wr_addr  = 2'd3;
      wr_data  = 8'hFF;
      rd_addr  = 2'd0;
      for (int k = 0; k < 2; k++) begin
         act[k] = 0; st[k] = 0; ewa[k] = 2'd0; ewd[k] = 8'd0;
         for (int i = 0; i < 4; i++) shd[k][i] = 8'd0;
      end

      // reset held low with a request pending: nothing may be accepted
      repeat (3) step();
      reset_b  = 1'b1;
      wr_valid = 1'b0;
      step();

      // single write at defaults: addr 2 / 0xA5
      wr_valid = 1'b1; wr_addr = 2'd2; wr_data = 8'hA5; rd_addr = 2'd2;
      step();
      wr_valid = 1'b0;
      repeat (14) step();

      // burst of three
      wr_valid = 1'b1; wr_addr = 2'd0; wr_data = 8'h11; step();
      wr_addr = 2'd1; wr_data = 8'h22; step();
      wr_addr = 2'd3; wr_data = 8'h33;
      while (!wr_ready[0]) step();
      step();
      wr_valid = 1'b0; rd_addr = 2'd1;
      repeat (45) step();

      // shadow write addr 1 = 0x5C, then reset during the first PULSE cycle
      // with one more entry queued
      wr_valid = 1'b1; wr_addr = 2'd1; wr_data = 8'h5C; step();
      wr_addr = 2'd2; wr_data = 8'h77; step();
      wr_valid = 1'b0;
      n = 0;
      while (we_b[0] !== 1'b0 && n < 20) begin step(); n++; end
      chk("wait_pulse", 32'(n < 20), 32'd1);
      reset_b = 1'b0; step();
      reset_b = 1'b1; repeat (3) step();

      // randomized traffic with occasional resets
      for (int i = 0; i < 1500; i++) begin
         wr_valid = ($urandom_range(0, 3) != 0) && ((i / 200) % 2 == 0 || $urandom_range(0, 5) == 0);
         wr_addr  = 2'($urandom_range(0, 3));
         wr_data  = 8'($urandom);
         rd_addr  = 2'($urandom_range(0, 3));
         reset_b  = ($urandom_range(0, 150) != 0);
         step();
      end
      reset_b = 1'b1; wr_valid = 1'b0;
      repeat (30) step();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
